// File: rtl/fft_seq_pkg.sv
// -----------------------------------------------------------------------------
// fft_seq_pkg
// Shared types and constants for the FFT frame sequencer.
//   N         : FFT frame length (power of two, >= 4)
//   LOG2N     : width of the in-frame sample counters
//   TAG_DEPTH : frames that may be in flight between FFT input and output
//   seq_state_e : input-side FSM states (IDLE, RUN)
//   src_idx_t   : source index carried through the tag FIFO
// -----------------------------------------------------------------------------
package fft_seq_pkg;

    localparam int N         = 64;
    localparam int LOG2N     = $clog2(N);
    localparam int TAG_DEPTH = 4;

    // Terminal count for the in-frame counters (sample N-1).
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

    typedef logic src_idx_t;

    // Round-robin pick between the two sources. When both request, the one
    // not served last wins; otherwise the single requester is chosen.
    function automatic src_idx_t rr_pick(input logic v0, input logic v1,
                                         input src_idx_t last_served);
        src_idx_t pick;
        if (v0 && v1) begin
            pick = ~last_served;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_tag_fifo.sv
// -----------------------------------------------------------------------------
// fft_tag_fifo
// Small synchronous FIFO holding the source index of each frame that has
// entered the FFT but not yet left it.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   push_i   : write din_i (ignored when full; the arbiter never pushes on full)
//   pop_i    : drop the head entry (ignored when empty)
//   din_i    : source index to store
//   dout_o   : head entry (valid when empty_o = 0)
//   full_o   : DEPTH entries stored
//   empty_o  : no entries stored
// -----------------------------------------------------------------------------
module fft_tag_fifo
    import fft_seq_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  logic     pop_i,
    input  src_idx_t din_i,
    output src_idx_t dout_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// fft_frame_sequencer
// Frame-level scheduler in front of a non-stalling N-point FFT pipeline.
// Two sample sources are arbitrated (round-robin) into whole, non-interleaved
// N-sample frames. Each granted frame's source index is queued in a tag FIFO
// and re-attached, with first/last markers, to the FFT output stream.
//
// Ports
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   s0_*/s1_*                     : source valid/ready handshakes and samples
//   fft_idata_en_o, fft_idata_*_o : registered sample stream to the FFT input
//   fft_odata_en_i, fft_odata_*_i : FFT output stream
//   m_valid_o, m_data_*_o         : registered output samples (no backpressure)
//   m_src_o                       : source index of the current output frame
//   m_first_o, m_last_o           : sample 0 / sample N-1 of the output frame
//   busy_o                        : frame being granted or frames in flight
//   err_orphan_o                  : sticky, FFT output seen with no tag queued
// -----------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // source 0
    input  logic             s0_valid_i,
    output logic             s0_ready_o,
    input  logic [WIDTH-1:0] s0_data_r_i,
    input  logic [WIDTH-1:0] s0_data_i_i,
    // source 1
    input  logic             s1_valid_i,
    output logic             s1_ready_o,
    input  logic [WIDTH-1:0] s1_data_r_i,
    input  logic [WIDTH-1:0] s1_data_i_i,
    // FFT input side
    output logic             fft_idata_en_o,
    output logic [WIDTH-1:0] fft_idata_r_o,
    output logic [WIDTH-1:0] fft_idata_i_o,
    // FFT output side
    input  logic             fft_odata_en_i,
    input  logic [WIDTH-1:0] fft_odata_r_i,
    input  logic [WIDTH-1:0] fft_odata_i_i,
    // tagged output stream
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_r_o,
    output logic [WIDTH-1:0] m_data_i_o,
    output logic             m_src_o,
    output logic             m_first_o,
    output logic             m_last_o,
    // status
    output logic             busy_o,
    output logic             err_orphan_o
);

    // ------------------------------------------------------------------
    // Input-side state
    // ------------------------------------------------------------------
    seq_state_e       state_q, state_d;
    src_idx_t         gnt_q, gnt_d;
    src_idx_t         last_q, last_d;
    logic [LOG2N-1:0] in_cnt_q, in_cnt_d;

    logic [1:0]       src_valid;
    logic [1:0]       src_ready;
    src_idx_t         pick;
    logic             grant_take;
    logic             accept;
    logic             frame_done;

    // FFT input register
    logic             idata_en_q;
    logic [WIDTH-1:0] idata_r_q, idata_r_d;
    logic [WIDTH-1:0] idata_i_q, idata_i_d;

    // ------------------------------------------------------------------
    // Output-side state
    // ------------------------------------------------------------------
    logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
    logic             m_valid_q;
    logic [WIDTH-1:0] m_data_r_q, m_data_r_d;
    logic [WIDTH-1:0] m_data_i_q, m_data_i_d;
    logic             m_src_q, m_src_d;
    logic             m_first_q, m_first_d;
    logic             m_last_q, m_last_d;
    logic             err_orphan_q, err_orphan_d;

    // Tag FIFO
    logic             tag_push;
    logic             tag_pop;
    src_idx_t         tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic             out_at_last;

    assign src_valid = {s1_valid_i, s0_valid_i};
    assign pick      = rr_pick(s0_valid_i, s1_valid_i, last_q);

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A frame may only start if its tag has somewhere to go.
                if ((|src_valid) && !tag_full) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (frame_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs / control strobes
    // ------------------------------------------------------------------
    always_comb begin
        src_ready  = '0;
        grant_take = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                // No ready in IDLE; the grant itself takes one cycle.
                grant_take = (|src_valid) & ~tag_full;
            end
            RUN: begin
                // Only the granted source is ever ready, so frames never
                // interleave on the FFT input.
                src_ready[gnt_q] = 1'b1;
                accept           = src_valid[gnt_q];
            end
            default: begin
                grant_take = 1'b0;
            end
        endcase
    end

    assign frame_done = accept && (in_cnt_q == CNT_LAST);
    assign s0_ready_o = src_ready[0];
    assign s1_ready_o = src_ready[1];

    // ------------------------------------------------------------------
    // Grant, frame counter, round-robin pointer, input register
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d     = gnt_q;
        last_d    = last_q;
        in_cnt_d  = in_cnt_q;
        idata_r_d = idata_r_q;
        idata_i_d = idata_i_q;
        if (grant_take) begin
            gnt_d    = pick;
            in_cnt_d = '0;
        end else if (accept) begin
            // Wraps to 0 after sample N-1.
            in_cnt_d = in_cnt_q + LOG2N'(1);
        end
        if (frame_done) begin
            last_d = gnt_q;
        end
        if (accept) begin
            idata_r_d = gnt_q ? s1_data_r_i : s0_data_r_i;
            idata_i_d = gnt_q ? s1_data_i_i : s0_data_i_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q      <= 1'b0;
            // "Last served = 1" makes source 0 win the first tie.
            last_q     <= 1'b1;
            in_cnt_q   <= '0;
            idata_en_q <= 1'b0;
            idata_r_q  <= '0;
            idata_i_q  <= '0;
        end else begin
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            in_cnt_q   <= in_cnt_d;
            idata_en_q <= accept;
            idata_r_q  <= idata_r_d;
            idata_i_q  <= idata_i_d;
        end
    end

    assign fft_idata_en_o = idata_en_q;
    assign fft_idata_r_o  = idata_r_q;
    assign fft_idata_i_o  = idata_i_q;

    // ------------------------------------------------------------------
    // Tag FIFO: push on grant, pop on the last output sample of a frame
    // ------------------------------------------------------------------
    assign out_at_last = (out_cnt_q == CNT_LAST);
    assign tag_push    = grant_take;
    assign tag_pop     = fft_odata_en_i & out_at_last;

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tag_push),
        .pop_i   (tag_pop),
        .din_i   (pick),
        .dout_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // ------------------------------------------------------------------
    // Output path: one register stage with tag and markers attached
    // ------------------------------------------------------------------
    always_comb begin
        out_cnt_d    = out_cnt_q;
        m_data_r_d   = m_data_r_q;
        m_data_i_d   = m_data_i_q;
        // Markers and source are qualified by the strobe so they read 0
        // between samples.
        m_src_d      = fft_odata_en_i & ~tag_empty & tag_head;
        m_first_d    = fft_odata_en_i & (out_cnt_q == '0);
        m_last_d     = fft_odata_en_i & out_at_last;
        err_orphan_d = err_orphan_q;
        if (fft_odata_en_i) begin
            out_cnt_d  = out_cnt_q + LOG2N'(1);
            m_data_r_d = fft_odata_r_i;
            m_data_i_d = fft_odata_i_i;
            // Data is still forwarded; the flag records that it had no owner.
            if (tag_empty) begin
                err_orphan_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt_q    <= '0;
            m_valid_q    <= 1'b0;
            m_data_r_q   <= '0;
            m_data_i_q   <= '0;
            m_src_q      <= 1'b0;
            m_first_q    <= 1'b0;
            m_last_q     <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            out_cnt_q    <= out_cnt_d;
            m_valid_q    <= fft_odata_en_i;
            m_data_r_q   <= m_data_r_d;
            m_data_i_q   <= m_data_i_d;
            m_src_q      <= m_src_d;
            m_first_q    <= m_first_d;
            m_last_q     <= m_last_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign m_valid_o    = m_valid_q;
    assign m_data_r_o   = m_data_r_q;
    assign m_data_i_o   = m_data_i_q;
    assign m_src_o      = m_src_q;
    assign m_first_o    = m_first_q;
    assign m_last_o     = m_last_q;
    assign err_orphan_o = err_orphan_q;
    assign busy_o       = (state_q == RUN) | ~tag_empty;

endmodule
